pipo_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register between N requesters. Each requester presents a data word and raises a request. The arbiter grants one requester at a time and loads that requester's word into the shared register. It follows a four-phase req/gnt handshake and reports which requester owns the current contents. It sits directly in front of the shared register bank and replaces direct drive of the register's parallel input.

---
 rtl/pipo_arbiter.sv | 115 +++++++++++
 tb/tb_pipo_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipo_arbiter.sv
// Round-robin req/gnt arbiter that loads the winning requester's word into one shared PIPO register.
// Define PIPO_ARB_RR_EN for round-robin selection; left undefined, the lowest index always wins.
module pipo_arbiter #(
   parameter int WIDTH = 5,
   parameter int N     = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] din,
   output logic [N-1:0]       gnt,
   output logic [WIDTH-1:0]   out,
   output logic               out_vld,
   output logic [ID_W-1:0]    owner,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            state_q;
   logic [N-1:0]      gnt_q;
   logic [WIDTH-1:0]  out_q;
   logic              vld_q;
   logic [ID_W-1:0]   owner_q;
   logic              busy_q;
   logic [ID_W-1:0]   win_q;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   sel_idx;

`ifdef PIPO_ARB_RR_EN
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   ptr_d;

   assign ptr   = ptr_q;
   assign ptr_d = (win_q == ID_W'(N-1)) ? '0 : win_q + 1'b1;
`else
   assign ptr = '0;
`endif

   // Scan from the far end of the rotation so the last hit is the first in ptr order.
   always_comb begin
      sel_idx = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N])
            sel_idx = ID_W'((int'(ptr) + k) % N);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         win_q   <= '0;
`ifdef PIPO_ARB_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  win_q   <= sel_idx;
                  gnt_q   <= N'(1) << sel_idx;
                  busy_q  <= 1'b1;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (req[win_q]) begin
                  out_q   <= din[int'(win_q)*WIDTH +: WIDTH];
                  owner_q <= win_q;
                  vld_q   <= 1'b1;
`ifdef PIPO_ARB_RR_EN
                  ptr_q   <= ptr_d;
`endif
                  state_q <= HOLD;
               end else begin
                  // Withdrawn before the load: release without touching out or ptr.
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            HOLD: begin
               if (!req[win_q]) begin
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign out     = out_q;
   assign out_vld = vld_q;
   assign owner   = owner_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_pipo_arbiter.sv
// Directed table-driven bench for pipo_arbiter plus hand sequences for fairness and data stability.
module tb_pipo_arbiter;

   localparam int WIDTH = 5;
   localparam int N     = 4;
   localparam int ID_W  = 2;

`ifdef PIPO_ARB_RR_EN
   localparam logic       RR     = 1'b1;
   localparam logic [3:0] WD_GNT = 4'b1000;
   localparam logic [1:0] WD_OWN = 2'd3;
`else
   localparam logic       RR     = 1'b0;
   localparam logic [3:0] WD_GNT = 4'b0001;
   localparam logic [1:0] WD_OWN = 2'd0;
`endif

   logic               clk;
   logic               clr;
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] din;
   logic [N-1:0]       gnt;
   logic [WIDTH-1:0]   out;
   logic               out_vld;
   logic [ID_W-1:0]    owner;
   logic               busy;

   pipo_arbiter #(.WIDTH(WIDTH), .N(N), .ID_W(ID_W)) dut (
      .clk(clk), .clr(clr), .req(req), .din(din),
      .gnt(gnt), .out(out), .out_vld(out_vld), .owner(owner), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       clr;
      logic [3:0] req;
      logic [19:0] din;
      logic [3:0] gnt;
      logic [4:0] out;
      logic       vld;
      logic [1:0] own;
      logic       busy;
   } vec_t;

   localparam int NV = 17;
   vec_t tv [NV];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic c, input logic [3:0] r, input logic [19:0] d,
                               input logic [3:0] g, input logic [4:0] o, input logic v,
                               input logic [1:0] ow, input logic b);
      vec_t t;
      t.clr = c; t.req = r; t.din = d; t.gnt = g; t.out = o; t.vld = v; t.own = ow; t.busy = b;
      return t;
   endfunction

   function automatic logic [19:0] pk(input logic [4:0] d3, input logic [4:0] d2,
                                      input logic [4:0] d1, input logic [4:0] d0);
      return {d3, d2, d1, d0};
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  exp_g;
      logic [19:0] dv;
      int          w;

      clr = 1'b1;
      req = '0;
      din = '0;

      //              clr  req      din                                     gnt      out       vld own   busy
      tv[0]  = mk(1'b1, 4'b1111, pk(5'd0, 5'd0, 5'd0, 5'd0),                4'b0000, 5'b00000, 0, 2'd0, 0);
      tv[1]  = mk(1'b1, 4'b1111, pk(5'd0, 5'd0, 5'd0, 5'd0),                4'b0000, 5'b00000, 0, 2'd0, 0);
      tv[2]  = mk(1'b0, 4'b1111, pk(5'd0, 5'd0, 5'd0, 5'h0A),               4'b0001, 5'b00000, 0, 2'd0, 1);
      tv[3]  = mk(1'b0, 4'b1111, pk(5'd0, 5'd0, 5'd0, 5'h0A),               4'b0001, 5'h0A,    1, 2'd0, 1);
      tv[4]  = mk(1'b0, 4'b0000, pk(5'd0, 5'd0, 5'd0, 5'd0),                4'b0000, 5'h0A,    0, 2'd0, 0);
      tv[5]  = mk(1'b0, 4'b0100, pk(5'd0, 5'b10110, 5'd0, 5'd0),            4'b0100, 5'h0A,    0, 2'd0, 1);
      tv[6]  = mk(1'b0, 4'b0100, pk(5'd0, 5'b10110, 5'd0, 5'd0),            4'b0100, 5'b10110, 1, 2'd2, 1);
      tv[7]  = mk(1'b0, 4'b0100, pk(5'd0, 5'b10110, 5'd0, 5'd0),            4'b0100, 5'b10110, 0, 2'd2, 1);
      tv[8]  = mk(1'b0, 4'b0000, pk(5'd0, 5'd0, 5'd0, 5'd0),                4'b0000, 5'b10110, 0, 2'd2, 0);
      tv[9]  = mk(1'b0, 4'b0010, pk(5'd0, 5'd0, 5'b01111, 5'd0),            4'b0010, 5'b10110, 0, 2'd2, 1);
      tv[10] = mk(1'b0, 4'b0000, pk(5'd0, 5'd0, 5'b01111, 5'd0),            4'b0000, 5'b10110, 0, 2'd2, 0);
      tv[11] = mk(1'b0, 4'b1111, pk(5'b00101, 5'd0, 5'd0, 5'b00101),        WD_GNT,  5'b10110, 0, 2'd2, 1);
      tv[12] = mk(1'b0, 4'b1111, pk(5'b00101, 5'd0, 5'd0, 5'b00101),        WD_GNT,  5'b00101, 1, WD_OWN, 1);
      tv[13] = mk(1'b0, 4'b0000, pk(5'd0, 5'd0, 5'd0, 5'd0),                4'b0000, 5'b00101, 0, WD_OWN, 0);
      tv[14] = mk(1'b0, 4'b1000, pk(5'b11111, 5'd0, 5'd0, 5'd0),            4'b1000, 5'b00101, 0, WD_OWN, 1);
      tv[15] = mk(1'b1, 4'b1000, pk(5'b11111, 5'd0, 5'd0, 5'd0),            4'b0000, 5'b00000, 0, 2'd0, 0);
      tv[16] = mk(1'b0, 4'b0000, pk(5'b11111, 5'd0, 5'd0, 5'd0),            4'b0000, 5'b00000, 0, 2'd0, 0);

      for (int i = 0; i < NV; i++) begin
         clr = tv[i].clr;
         req = tv[i].req;
         din = tv[i].din;
         tick();
         check("gnt",     i, 32'(gnt),     32'(tv[i].gnt));
         check("out",     i, 32'(out),     32'(tv[i].out));
         check("out_vld", i, 32'(out_vld), 32'(tv[i].vld));
         check("owner",   i, 32'(owner),   32'(tv[i].own));
         check("busy",    i, 32'(busy),    32'(tv[i].busy));
      end

      // Fairness: all request, winner drops after its load and re-raises once back in IDLE.
      dv = pk(5'd24, 5'd17, 5'd10, 5'd3);
      din = dv;
      for (int t = 0; t < 5; t++) begin
         w = RR ? (t % N) : 0;
         exp_g = 4'b0001 << w;
         req = 4'b1111;
         tick();
         check("rr_gnt", t, 32'(gnt), 32'(exp_g));
         tick();
         check("rr_out",   t, 32'(out),     32'(dv[w*WIDTH +: WIDTH]));
         check("rr_owner", t, 32'(owner),   32'(w));
         check("rr_vld",   t, 32'(out_vld), 32'd1);
         req = 4'b1111 & ~exp_g;
         tick();
         check("rr_rel", t, 32'(gnt), 32'd0);
      end

      // Data stability: din changes while HOLD must not reach out or re-pulse out_vld.
      clr = 1'b1;
      req = '0;
      tick();
      clr = 1'b0;
      req = 4'b0100;
      din = pk(5'd0, 5'b00011, 5'd0, 5'd0);
      tick();
      check("ds_gnt", 0, 32'(gnt), 32'b0100);
      tick();
      check("ds_out", 0, 32'(out),     32'b00011);
      check("ds_vld", 0, 32'(out_vld), 32'd1);
      din = pk(5'd0, 5'b11100, 5'd0, 5'd0);
      for (int k = 1; k < 3; k++) begin
         tick();
         check("ds_out", k, 32'(out),     32'b00011);
         check("ds_vld", k, 32'(out_vld), 32'd0);
         check("ds_gnt", k, 32'(gnt),     32'b0100);
      end
      req = '0;
      tick();
      check("ds_rel",  0, 32'(gnt),  32'd0);
      check("ds_busy", 0, 32'(busy), 32'd0);
      check("ds_out",  3, 32'(out),  32'b00011);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
